fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Top-level run controller for the instruction-fetch PC unit. Decodes per-instruction branch class,
//  Zero flag and halt/memory flags into the fetch unit's BranchEZ/BranchNZ/BranchAlways/Done controls.
//  Runs a Start/Halted program handshake, stalls the PC on multi-cycle memory instructions and
//  counts committed instructions. Sits between decode/ALU/data-memory and the PC register.
// PARAMETERS
//  CW       16  width of committed-instruction counter InstrCount
//  TIMEOUT  16  max WAIT cycles before fault (used only with FETCH_WATCHDOG_EN)
// PORTS
//  Clk           in   1   clock, all state on rising edge
//  Reset         in   1   synchronous, active-high; highest priority
//  Start         in   1   level/pulse; begins execution from IDLE
//  BrOp          in   2   branch class of current instr: 00 none, 01 BEZ, 10 BNZ, 11 always
//  Zero          in   1   ALU zero flag for current instr
//  IsHalt        in   1   current instr is HALT
//  IsMem         in   1   current instr is a data-memory access needing MemAck
//  MemAck        in   1   data memory completes access this cycle
//  BranchEZ      out  1   to fetch: branch-if-zero request
//  BranchNZ      out  1   to fetch: branch-if-nonzero request
//  BranchAlways  out  1   to fetch: unconditional branch request
//  Done          out  1   to fetch: 1 = hold PC (no increment)
//  CommitEn      out  1   current instr retires this cycle (gates reg-file/mem writes)
//  Busy          out  1   state is RUN or WAIT
//  Halted        out  1   state is HALT (program-done handshake)
//  Fault         out  1   watchdog fault, sticky until Reset
//  InstrCount    out  CW  committed instructions since Reset
// BEHAVIOUR
//  States: IDLE (reset state), RUN, WAIT, HALT. All outputs combinational from state + inputs,
//   except InstrCount and Fault (registered).
//  Reset: next state IDLE; InstrCount=0, Fault=0. In Reset cycle and IDLE: Done=1, Branch*=0,
//   CommitEn=0, Busy=0, Halted=0. Reset mid-RUN/WAIT/HALT aborts immediately; no commit that cycle.
//  IDLE: Start=1 -> RUN next cycle (first instr at PC 0 executes in RUN). Start=0 -> stay.
//  RUN, priority order:
//   IsHalt=1       -> Done=1, CommitEn=0, Branch*=0; next HALT. BrOp/IsMem ignored.
//   IsMem & !MemAck-> Done=1, CommitEn=0, Branch*=0; next WAIT.
//   IsMem &  MemAck-> single-cycle: Done=0, CommitEn=1, Branch*=0; stay RUN.
//   else           -> Done=0, CommitEn=1; BranchEZ=(BrOp==01), BranchNZ=(BrOp==10),
//                     BranchAlways=(BrOp==11); stay RUN. Zero passed through to fetch, not gated here.
//   Exactly one Branch* high at most, in any state.
//  WAIT: Done=1, CommitEn=0, Branch* =0 until MemAck=1; that cycle Done=0, CommitEn=1, next RUN.
//   Inputs other than MemAck ignored in WAIT (instr latched by held PC).
//  HALT: Done=1, Halted=1, CommitEn=0; exit only via Reset. Start ignored.
//  Start ignored outside IDLE. Start and Reset same cycle -> Reset wins.
//  InstrCount: +1 on every CommitEn cycle; saturates at 2^CW-1 (no wrap).
//  Latency: branch/Done decisions take effect at the next posedge in the fetch PC (0 added cycles).
// CONFIGURATION
//  FETCH_WATCHDOG_EN defined: counter clears on WAIT entry, +1 per WAIT cycle without MemAck;
//   reaching TIMEOUT cycles without MemAck -> next state HALT, Fault=1 (sticky), no commit.
//   MemAck on the TIMEOUT-th cycle wins (normal commit, no fault).
//  Not defined: no counter, WAIT waits indefinitely, Fault tied 0.
// TESTING
//  Reset, Start=1 one cycle, 5 plain instrs (BrOp=00) -> Done=0 each, InstrCount=5, Busy=1.
//  RUN, BrOp=01 Zero=1 -> BranchEZ=1 only, CommitEn=1; BrOp=10 -> BranchNZ=1; BrOp=11 -> BranchAlways=1.
//  IsMem=1, MemAck after 3 cycles -> Done=1 for 3 cycles in WAIT, then one commit, back to RUN, count +1.
//  IsHalt=1 in RUN -> next cycle Halted=1, Done=1; Start pulses ignored; count unchanged.
//  Reset asserted in WAIT -> next cycle IDLE, InstrCount=0, Busy=0, Done=1.
//  FETCH_WATCHDOG_EN, TIMEOUT=16, no MemAck -> after 16 WAIT cycles HALT, Fault=1; CW=4 -> count saturates at 15.

Source files
------------

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Run controller for the instruction-fetch PC unit. Turns the current
//   instruction's branch class, halt flag and memory flags into the fetch
//   unit's BranchEZ / BranchNZ / BranchAlways / Done controls, runs the
//   Start -> Halted program handshake, holds the PC while a data-memory access
//   is outstanding and counts retired instructions.
//
// Optional feature:
//   FETCH_WATCHDOG_EN  when defined, a WAIT that sees no MemAck for TIMEOUT
//                      consecutive cycles aborts to HALT and raises a sticky
//                      Fault. When undefined, WAIT waits forever and Fault=0.
//
// Parameters:
//   CW       width of InstrCount
//   TIMEOUT  WAIT cycles without MemAck before a fault (watchdog build only)
//
// Ports:
//   Clk, Reset       clock (rising edge), synchronous active-high reset
//   Start            begins execution when IDLE
//   BrOp[1:0]        00 none, 01 BEZ, 10 BNZ, 11 always
//   Zero             ALU zero flag (resolved by fetch, not used here)
//   IsHalt, IsMem    current instruction is HALT / a data-memory access
//   MemAck           data memory completes the access this cycle
//   BranchEZ/NZ/Always  branch requests to fetch (at most one high)
//   Done             1 = hold PC
//   CommitEn         current instruction retires this cycle
//   Busy, Halted     state is RUN/WAIT, state is HALT
//   Fault            watchdog fault, sticky until Reset
//   InstrCount       retired instructions since Reset, saturating
//   dbg_state        current FSM state (0 IDLE, 1 RUN, 2 WAIT, 3 HALT)
//
// Handshake: Start is sampled only in IDLE; MemAck is sampled only while the
// current instruction is a memory access (RUN with IsMem, or WAIT). A cycle
// with CommitEn=1 is exactly one retired instruction.
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int CW      = 16,
  parameter int TIMEOUT = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [1:0]    BrOp,
  input  logic          Zero,
  input  logic          IsHalt,
  input  logic          IsMem,
  input  logic          MemAck,
  output logic          BranchEZ,
  output logic          BranchNZ,
  output logic          BranchAlways,
  output logic          Done,
  output logic          CommitEn,
  output logic          Busy,
  output logic          Halted,
  output logic          Fault,
  output logic [CW-1:0] InstrCount,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   wd_expire;

  // Zero is consumed by the fetch unit itself; the branch condition is not
  // evaluated here.
  logic unused_zero;
  assign unused_zero = Zero;

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef FETCH_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;
  logic           fault_q;

  // wd_cnt holds the number of ack-less WAIT cycles already seen, so the
  // TIMEOUT-th ack-less cycle is the one where it equals TIMEOUT-1. A MemAck
  // in that same cycle takes precedence.
  assign wd_expire = (state_q == ST_WAIT) && !MemAck &&
                     (wd_cnt == WDW'(TIMEOUT - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wd_cnt  <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state_q == ST_RUN)
        wd_cnt <= '0;
      else if (state_q == ST_WAIT && !MemAck)
        wd_cnt <= wd_cnt + 1'b1;
      if (wd_expire)
        fault_q <= 1'b1;
    end
  end

  assign Fault = fault_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_expire = 1'b0;
  assign Fault     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_RUN;
      ST_RUN: begin
        if (IsHalt)               state_d = ST_HALT;
        else if (IsMem && !MemAck) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (MemAck)         state_d = ST_RUN;
        else if (wd_expire) state_d = ST_HALT;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Reset forces the idle output set in its own cycle so an
  // abort mid-instruction never commits.
  // ---------------------------------------------------------------------------
  always_comb begin
    Done         = 1'b1;
    BranchEZ     = 1'b0;
    BranchNZ     = 1'b0;
    BranchAlways = 1'b0;
    CommitEn     = 1'b0;
    Busy         = 1'b0;
    Halted       = 1'b0;
    if (!Reset) begin
      case (state_q)
        ST_RUN: begin
          Busy = 1'b1;
          if (!IsHalt && !(IsMem && !MemAck)) begin
            Done     = 1'b0;
            CommitEn = 1'b1;
            // Memory instructions never branch.
            if (!IsMem) begin
              BranchEZ     = (BrOp == 2'b01);
              BranchNZ     = (BrOp == 2'b10);
              BranchAlways = (BrOp == 2'b11);
            end
          end
        end
        ST_WAIT: begin
          Busy = 1'b1;
          if (MemAck) begin
            Done     = 1'b0;
            CommitEn = 1'b1;
          end
        end
        ST_HALT: Halted = 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter, saturating at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset)
      InstrCount <= '0;
    else if (CommitEn && (InstrCount != {CW{1'b1}}))
      InstrCount <= InstrCount + 1'b1;
  end

endmodule
